// File: rtl/button_debounce_bank.sv
// Debounce bank for active-low arcade buttons: 2-flop synchroniser, per-channel
// stability counter, clean active-high levels and registered press/release strobes.
module button_debounce_bank #(
  parameter int NUM_BTN       = 5,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_BTN-1:0] sync_p0;
  logic [NUM_BTN-1:0] sync_p1;
  logic [NUM_BTN-1:0] pressed_s;

  // Stage p0/p1: metastability synchroniser, resets to the released (high) level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= btn_raw_n;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed_s = ~sync_p1;

  // Debounce stage: each channel owns its counter and strobe flops
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt            <= '0;
        btn_level[i]   <= 1'b0;
        btn_press[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
      end else begin
        btn_press[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
        if (pressed_s[i] == btn_level[i]) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          // Input held long enough: commit the new level and fire one strobe
          cnt            <= '0;
          btn_level[i]   <= pressed_s[i];
          btn_press[i]   <= pressed_s[i];
          btn_release[i] <= ~pressed_s[i];
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

  assign any_press = |btn_press;

endmodule

// File: doc/button_debounce_bank.md
Name: button_debounce_bank

Overview:
- Upstream conditioning stage for the five active-low arcade push-buttons: four target buttons plus the start button.
- Sits between the board pins and the game controller.
- Synchronises each raw button, debounces it with a per-channel stability counter, and presents clean active-high pressed levels.
- Also produces single-cycle press/release strobes, so the game logic no longer needs its own edge detection on raw pins.

Parameters:
- NUM_BTN, 5, number of independent button channels.
- STABLE_CYCLES, 1000000, consecutive clock cycles a synchronised input must differ from the debounced state before the state flips (10 ms at 100 MHz); legal range >= 2.
- CNT_W, $clog2(STABLE_CYCLES), width of each channel's stability counter (derived, not overridden).

Ports:
- clk  input  1  system clock, 100 MHz, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- btn_raw_n  input  NUM_BTN  raw pin levels, active-low (0 = pressed), asynchronous to clk.
- btn_level  output  NUM_BTN  debounced level, active-high (1 = pressed).
- btn_press  output  NUM_BTN  one-cycle strobe on debounced 0->1.
- btn_release  output  NUM_BTN  one-cycle strobe on debounced 1->0.
- any_press  output  1  OR of btn_press, same cycle.

Behaviour:
- Clock and reset:
  - One clock domain.
  - reset_n asynchronous assert, synchronous-safe deassert handled externally.
  - All flops clear immediately on reset_n=0.
- Reset values:
  - Synchroniser stages = 1 (released).
  - btn_level = 0.
  - btn_press = 0, btn_release = 0, any_press = 0.
  - All counters = 0.
- Synchroniser: per channel, 2-flop synchroniser on btn_raw_n. sync2 is the only value used downstream. pressed_s = ~sync2.
- Debounce, per channel, every rising edge:
  - If pressed_s == btn_level: counter <= 0, no strobe.
  - If pressed_s != btn_level and counter < STABLE_CYCLES-1: counter <= counter+1.
  - If pressed_s != btn_level and counter == STABLE_CYCLES-1:
    - btn_level <= pressed_s; counter <= 0.
    - btn_press <= pressed_s; btn_release <= ~pressed_s.
- Strobes are registered: high for exactly one cycle, coincident with the first cycle btn_level shows the new value. They are 0 in every other cycle.
- Latency, raw edge stable from edge E0 onward:
  - sync1 captures at E0, sync2 at E1.
  - Mismatch counted at E2..E(STABLE_CYCLES+1).
  - btn_level and the strobe update at edge E(STABLE_CYCLES+1).
  - Total is STABLE_CYCLES+2 edges including E0.
- Glitch rejection: any cycle where pressed_s returns to btn_level clears the counter. A bounce shorter than STABLE_CYCLES consecutive cycles never changes btn_level and never strobes.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around.
- Channels are fully independent. Simultaneous presses on several channels yield simultaneous strobes in the same cycle. any_press is high if any bit is set.
- Reset mid-count discards the partial count. After release of reset the channel starts from the released state. A button held through reset produces a fresh btn_press after STABLE_CYCLES+2 edges.
- No combinational path from btn_raw_n to any output.

Test Plan:
Bench parameters: NUM_BTN=5, STABLE_CYCLES=4.
- Reset check: hold reset_n=0 with btn_raw_n=5'b00000 -> all outputs 0. Release, keep inputs low -> btn_level=5'b11111 at the 6th edge after release, btn_press=5'b11111 and any_press=1 for exactly that one cycle.
- Clean press/release on ch0: btn_raw_n[0] 1->0 before edge E0 -> btn_level[0]=1 and btn_press[0]=1 after E5, btn_press[0]=0 after E6. Raise it later -> btn_release[0] one-cycle pulse 6 edges after the rising raw edge.
- Bounce rejection on ch2: btn_raw_n[2] toggles low 3 cycles, high 1, low 3, high -> btn_level[2] stays 0, no strobes, counter returns to 0.
- Simultaneous presses: ch1 and ch4 fall on the same cycle -> btn_press=5'b10010 for one cycle, any_press=1. Other channels are unaffected.
- Mid-count reset: ch3 low for 3 cycles, assert reset_n=0 for 2 cycles, release with ch3 still low -> no strobe before reset. btn_press[3] fires exactly 6 edges after release.
- Long hold: ch0 low for 100 cycles -> exactly one btn_press[0] pulse, btn_level[0] stays 1 throughout, no further strobes.
